// File: rtl/hit_judge_array.sv
// hit_judge_array: per-lane press edge detection with lockout, hit-window grading,
// lowest-lane-first judgement emission, and combo / max-combo tracking.
module hit_judge_array #(
    parameter int LANES      = 4,
    parameter int LANE_W     = 16,
    parameter int DEB_CYCLES = 10,
    parameter int COMBO_W    = 8,
    localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    system_clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [LANES-1:0]        button,
    input  logic [LANES*LANE_W-1:0] channel,
    output logic                    out_valid,
    output logic [LW-1:0]           out_lane,
    output logic [1:0]              out_grade,
    output logic [COMBO_W-1:0]      combo,
    output logic [COMBO_W-1:0]      max_combo
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [LANES-1:0]   prev_button, pending, accept, hit, clear;
    logic [CW-1:0]      lock_cnt [LANES];
    logic [1:0]         grade [LANES];
    logic [3:0]         win [LANES];
    logic [LW-1:0]      sel;
    logic [COMBO_W-1:0] combo_next;

    // A press that is accepted with a non-one-hot window still locks the lane (ghost press).
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign win[g]    = channel[g*LANE_W + LANE_W - 4 +: 4];
        assign accept[g] = run && button[g] && !prev_button[g] && lock_cnt[g] == '0;
        assign hit[g]    = accept[g] && (win[g] == 4'b0001 || win[g] == 4'b0010 ||
                                         win[g] == 4'b0100 || win[g] == 4'b1000);
    end

    always_comb begin
        sel = '0;
        for (int i = LANES - 1; i >= 0; i--)
            if (pending[i]) sel = LW'(i);
        clear      = (|pending) ? (LANES'(1) << sel) : '0;
        combo_next = (grade[sel] == 2'b00) ? '0 : (&combo) ? combo : combo + 1'b1;
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            prev_button <= '0;
            pending     <= '0;
            out_valid   <= 1'b0;
            out_lane    <= '0;
            out_grade   <= 2'b01;
            combo       <= '0;
            max_combo   <= '0;
            for (int i = 0; i < LANES; i++) begin
                lock_cnt[i] <= '0;
                grade[i]    <= '0;
            end
        end else begin
            prev_button <= button;
            pending     <= (pending & ~clear) | hit;
            out_valid   <= |pending;
            for (int i = 0; i < LANES; i++) begin
                if (accept[i])
                    lock_cnt[i] <= CW'(DEB_CYCLES);
                else if (run && lock_cnt[i] != '0)
                    lock_cnt[i] <= lock_cnt[i] - 1'b1;
                if (hit[i])
                    grade[i] <= {win[i][3] | win[i][2], win[i][3] | win[i][1]};
            end
            if (|pending) begin
                out_lane  <= sel;
                out_grade <= grade[sel];
                combo     <= combo_next;
                if (combo_next > max_combo)
                    max_combo <= combo_next;
            end
        end
    end
endmodule

// File: doc/hit_judge_array.md
HIT_JUDGE_ARRAY -- requirements
Module: hit_judge_array

Parameters
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of button lanes (range 1..16).
REQ-002 The block SHALL have parameter LANE_W, default 16, giving the width of each lane's note-channel word (≥4).
REQ-003 The block SHALL have parameter DEB_CYCLES, default 10, giving the lockout length in clocks after an accepted press; DEB_CYCLES ≥ LANES is required.
REQ-004 The block SHALL have parameter COMBO_W, default 8, giving the combo counter width.

Interface
REQ-005 The block SHALL have port system_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port run, input, 1 bit: enables acceptance of new presses and lockout countdown.
REQ-008 The block SHALL have port button, input, LANES bits: per-lane button level, already synchronised to system_clk.
REQ-009 The block SHALL have port channel, input, LANES*LANE_W bits: lane i occupies bits [i*LANE_W +: LANE_W], and its top 4 bits are the one-hot hit window.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse per emitted judgement.
REQ-011 The block SHALL have port out_lane, output, clog2(LANES) bits (minimum 1 bit): the lane of the emitted judgement.
REQ-012 The block SHALL have port out_grade, output, 2 bits, encoded BAD=00, NORMAL=01, NICE=10, GREAT=11.
REQ-013 The block SHALL have port combo, output, COMBO_W bits: the current combo count.
REQ-014 The block SHALL have port max_combo, output, COMBO_W bits: the highest combo count since reset.

Function
REQ-015 The block SHALL register button every cycle into prev_button, regardless of run.
REQ-016 The block SHALL treat lane i as having a press edge when button[i]=1 and prev_button[i]=0.
REQ-017 The block SHALL accept a press on lane i only when run=1 and lock_cnt[i]=0.
REQ-018 On an accepted press, the block SHALL load lock_cnt[i] with DEB_CYCLES.
REQ-019 While run=1, the block SHALL decrement each nonzero lock_cnt by one per cycle; while run=0, lock counters SHALL hold their value.
REQ-020 A press edge seen while the lane is locked or while run=0 SHALL be ignored entirely: no pending entry is created and lock_cnt is not reloaded.
REQ-021 On an accepted press, the block SHALL decode the lane's top 4 window bits in the same cycle: 0001→BAD, 0010→NORMAL, 0100→NICE, 1000→GREAT.
REQ-022 For a decoded grade, the block SHALL set pending[i] and store grade[i].
REQ-023 Any other window pattern (including 0000 or multi-hot) SHALL still start the lockout but SHALL NOT create a pending entry (ghost press).
REQ-024 Each cycle, if any pending bit is set, the block SHALL emit exactly one judgement: the lowest-index pending lane, with its pending bit cleared.
REQ-025 Emission SHALL appear on registered outputs out_valid, out_lane and out_grade one cycle after the pending bit becomes visible; minimum press-to-out_valid latency is 2 clocks from the press-edge sample edge.
REQ-026 A lane's press and its own emission SHALL NOT collide; REQ-003 guarantees the pending bit drains before the lane can be re-accepted.
REQ-027 Simultaneous presses on several lanes SHALL all be captured in the same cycle and emitted on consecutive cycles in ascending lane order.
REQ-028 When no emission occurs, out_valid SHALL be 0, and out_lane and out_grade SHALL hold their last values.
REQ-029 Pending entries SHALL continue to drain while run=0.
REQ-030 Combo SHALL update in the same cycle out_valid is asserted.
REQ-031 An emitted grade other than BAD SHALL increment combo, saturating at 2^COMBO_W−1.
REQ-032 An emitted BAD SHALL clear combo to 0.
REQ-033 max_combo SHALL be updated to the new combo value whenever that value exceeds it; it is never decreased except by reset.

Reset
REQ-034 When rst=1 at a clock edge, the block SHALL return to reset state: out_valid=0, out_lane=0, out_grade=01 (NORMAL), combo=0, max_combo=0, all pending=0, all lock_cnt=0, prev_button=0.
REQ-035 Reset SHALL take priority over all other inputs, including mid-lockout and with pending entries queued; queued judgements are discarded and never emitted.
REQ-036 A button held high through reset release SHALL produce an edge on the first post-reset cycle, because prev_button resets to 0.

Verification (LANES=4, DEB_CYCLES=10, COMBO_W=8)
REQ-037 Bench SHALL drive lane 2 window 1000 and raise button[2] at edge t, and check out_valid=1, out_lane=2, out_grade=11 at t+2, combo=1.
REQ-038 Bench SHALL raise lanes 0, 1 and 3 together with windows 0100, 0001 and 0010, and check emissions on three consecutive cycles: (0,10), (1,00), (3,01); combo ends at 1.
REQ-039 Bench SHALL re-press lane 0 five cycles after an accepted press, check that no emission occurs, then press again 11 cycles after the first accepted press and check it is accepted.
REQ-040 Bench SHALL press a lane with window 0000, check that no out_valid occurs, and check that an immediate re-press is blocked for 10 cycles.
REQ-041 Bench SHALL issue 256 non-BAD hits and check combo=255 (saturated) and max_combo=255; then one BAD and check combo=0 and max_combo=255.
REQ-042 Bench SHALL assert rst with 3 pending entries and lock counters nonzero, and check no emission afterwards, all outputs at reset values, and that a press on the cycle after rst is accepted.
